// File: rtl/ddr5_request_queue_pkg.sv
// Shared types and DDR5 address bit positions for the request queue and
// the address-mapping stage.
package ddr5_request_queue_pkg;

    localparam int ADDR_W    = 34;
    localparam int CYCLE_W   = 64;
    localparam int ROW_HI    = 33;
    localparam int ROW_LO    = 18;
    localparam int COLH_HI   = 17;
    localparam int COLH_LO   = 12;
    localparam int BANK_HI   = 11;
    localparam int BANK_LO   = 10;
    localparam int BG_HI     = 9;
    localparam int BG_LO     = 7;
    localparam int CHAN_BIT  = 6;
    localparam int COLL_HI   = 5;
    localparam int COLL_LO   = 2;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef struct packed {
        logic [15:0] row;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [2:0]  bg;
        logic        chan;
    } addr_fields_t;

    // cycle is stored at the widest supported TIME_W; narrower builds truncate.
    typedef struct packed {
        logic [3:0]         core;
        op_e                op;
        logic [ADDR_W-1:0]  addr;
        logic [CYCLE_W-1:0] cycle;
    } req_t;

endpackage

// File: rtl/ddr5_request_queue_addr_decode.sv
// Combinational split of a 34-bit physical address into DDR5 row/col/bank/bg/chan.
// Shared with the address-mapping stage.
module ddr5_addr_decode
    import ddr5_request_queue_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output addr_fields_t      o_fields
);

    // addr[1:0] is sub-burst byte offset and never reaches the scheduler.
    logic w_unused_lsb;
    assign w_unused_lsb = ^i_addr[1:0];

    assign o_fields.row  = i_addr[ROW_HI:ROW_LO];
    assign o_fields.col  = {i_addr[COLH_HI:COLH_LO], i_addr[COLL_HI:COLL_LO]};
    assign o_fields.bank = i_addr[BANK_HI:BANK_LO];
    assign o_fields.bg   = i_addr[BG_HI:BG_LO];
    assign o_fields.chan = i_addr[CHAN_BIT];

endmodule

// File: rtl/ddr5_request_queue.sv
// In-order timestamped request queue feeding the DDR5 scheduler on DRAM edges.
// Optional trace/stall reporting is enabled with `define QUEUE_TRACE_EN.
module ddr5_request_queue
    import ddr5_request_queue_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TIME_W    = 64,
    parameter int CLK_RATIO = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TIME_W-1:0]        in_cycle,
    input  logic [3:0]               in_core,
    input  logic [1:0]               in_op,
    input  logic [ADDR_W-1:0]        in_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [3:0]               out_core,
    output logic [15:0]              out_row,
    output logic [9:0]               out_col,
    output logic [1:0]               out_bank,
    output logic [2:0]               out_bg,
    output logic                     out_chan,
    output logic [TIME_W-1:0]        out_arrival,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic [TIME_W-1:0]        cpu_time
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    req_t               r_mem [DEPTH];
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [OW-1:0]      r_occ;
    logic [TIME_W-1:0]  r_time;

    logic               w_dram_edge;
    logic               w_push;
    logic               w_pop;
    logic               w_skip;
    req_t               w_req;
    req_t               w_head;
    addr_fields_t       w_fields;

    generate
        if (CLK_RATIO > 1) begin : g_div
            assign w_dram_edge = (r_time[$clog2(CLK_RATIO)-1:0] == '0);
        end else begin : g_nodiv
            assign w_dram_edge = 1'b1;
        end
    endgenerate

    assign full      = (r_occ == OW'(DEPTH));
    assign in_ready  = !full && (in_cycle <= r_time);
    assign out_valid = (r_occ != '0) && w_dram_edge;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // Jump idle time forward to the next request instead of ticking toward it.
    assign w_skip    = (r_occ == '0) && in_valid && (in_cycle > r_time);

    assign w_req.core  = in_core;
    assign w_req.op    = op_e'(in_op);
    assign w_req.addr  = in_addr;
    assign w_req.cycle = CYCLE_W'(in_cycle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time <= '0;
        end else if (w_skip) begin
            r_time <= in_cycle;
        end else begin
            r_time <= r_time + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Entries are cleared on reset so the out_* fields read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_tail] <= w_req;
        end
    end

    assign w_head = r_mem[r_head];

    ddr5_addr_decode u_dec (
        .i_addr   (w_head.addr),
        .o_fields (w_fields)
    );

    assign out_op      = w_head.op;
    assign out_core    = w_head.core;
    assign out_row     = w_fields.row;
    assign out_col     = w_fields.col;
    assign out_bank    = w_fields.bank;
    assign out_bg      = w_fields.bg;
    assign out_chan    = w_fields.chan;
    assign out_arrival = w_head.cycle[TIME_W-1:0];
    assign occupancy   = r_occ;
    assign cpu_time    = r_time;

`ifdef QUEUE_TRACE_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid && full) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_push) begin
                $display("t=%0d ENQ core=%0d op=%0d addr=%09h occ=%0d",
                         r_time, in_core, in_op, in_addr, r_occ);
                if (in_op == 2'd3)
                    $display("t=%0d WARNING reserved op from core %0d", r_time, in_core);
            end
            if (w_pop)
                $display("t=%0d DEQ core=%0d op=%0d row=%04h bg=%0d bank=%0d col=%03h",
                         r_time, out_core, out_op, out_row, out_bg, out_bank, out_col);
        end
    end

    final $display("ddr5_request_queue: push stalls while full = %0d", r_stall_cnt);
`endif

endmodule

// File: tb/tb_ddr5_request_queue.sv
// Directed + randomized bench for ddr5_request_queue against a queue-based model.
module tb_ddr5_request_queue;

    localparam int DEPTH = 16;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_cycle, out_arrival, cpu_time;
    logic [3:0]  in_core, out_core;
    logic [1:0]  in_op, out_op, out_bank;
    logic [33:0] in_addr;
    logic [15:0] out_row;
    logic [9:0]  out_col;
    logic [2:0]  out_bg;
    logic        out_chan, full;
    logic [4:0]  occupancy;

    ddr5_request_queue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cycle(in_cycle),
        .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_core(out_core), .out_row(out_row), .out_col(out_col),
        .out_bank(out_bank), .out_bg(out_bg), .out_chan(out_chan),
        .out_arrival(out_arrival), .occupancy(occupancy), .full(full), .cpu_time(cpu_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  core;
        logic [1:0]  op;
        logic [33:0] addr;
        logic [63:0] cycle;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] mtime;
    int          checks = 0;
    int          errors = 0;
    int          npush  = 0;
    int          npop   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired", tag);
    endtask

    // One clock: compare outputs at the falling edge, then advance the model past the rising edge.
    task automatic do_cycle();
        logic  exp_ready, exp_valid, push, pop;
        mreq_t h, r;
        @(negedge clk);
        exp_ready = (mq.size() < DEPTH) && (in_cycle <= mtime);
        exp_valid = (mq.size() != 0) && (mtime % 2 == 0);
        chk("in_ready",  in_ready,  exp_ready);
        chk("out_valid", out_valid, exp_valid);
        chk("occupancy", occupancy, mq.size());
        chk("full",      full,      mq.size() == DEPTH);
        chk("cpu_time",  cpu_time,  mtime);
        if (exp_valid) begin
            h = mq[0];
            chk("out_core",    out_core,    h.core);
            chk("out_op",      out_op,      h.op);
            chk("out_row",     out_row,     h.addr >> 18);
            chk("out_col",     out_col,     ((h.addr >> 12) % 64) * 16 + (h.addr >> 2) % 16);
            chk("out_bank",    out_bank,    (h.addr >> 10) % 4);
            chk("out_bg",      out_bg,      (h.addr >> 7) % 8);
            chk("out_chan",    out_chan,    (h.addr >> 6) % 2);
            chk("out_arrival", out_arrival, h.cycle);
        end
        push = in_valid && exp_ready;
        pop  = exp_valid && out_ready;
        r = '{core: in_core, op: in_op, addr: in_addr, cycle: in_cycle};
        @(posedge clk);
        #1;
        if (mq.size() == 0 && in_valid && in_cycle > mtime) mtime = in_cycle;
        else mtime = mtime + 1;
        if (pop)  begin void'(mq.pop_front()); npop++;  end
        if (push) begin mq.push_back(r);        npush++; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        mtime = 0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; in_valid = 0; in_cycle = 0; in_core = 0; in_op = 0;
        in_addr = 0; out_ready = 0;

        // 1: reset state, then free-running time
        #3;
        chk("rst_occ",   occupancy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_full",  full,      0);
        chk("rst_time",  cpu_time,  0);
        chk("rst_row",   out_row,   0);
        do_reset();
        repeat (4) do_cycle();

        // 2: all-ones address decodes to maximal fields
        in_valid = 1; in_cycle = 0; in_core = 3; in_op = 1;
        in_addr = 34'h3FFFFFFFF; out_ready = 1;
        do_cycle();
        in_valid = 0;
        guard = 0;
        while (mq.size() != 0 && guard < 10) begin
            if (out_valid) begin
                chk("t2_row", out_row, 16'hFFFF);
                chk("t2_col", out_col, 10'h3FF);
            end
            do_cycle(); guard++;
        end
        if (guard >= 10) timeout("t2_pop");

        // 3: time-skip on an empty queue
        do_reset();
        out_ready = 0;
        while (mtime != 5) do_cycle();
        in_valid = 1; in_cycle = 100; in_core = 5; in_op = 2; in_addr = 34'h12345678;
        do_cycle();
        chk("t3_skip", cpu_time, 100);
        do_cycle();
        in_valid = 0;
        do_cycle();
        #3;
        chk("t3_vis102", {cpu_time == 100 + 2, out_valid}, 2'b11);
        out_ready = 1;
        do_cycle();
        out_ready = 0;

        // 4: fill to DEPTH, 17th stalls until one pop
        for (int i = 0; i < 17; i++) begin
            in_valid = 1; in_cycle = 0; in_core = 4'(i); in_op = 2'(i);
            in_addr = {$urandom, $urandom} % (64'd1 << 34);
            do_cycle();
        end
        chk("t4_full",  full,      1);
        chk("t4_occ",   occupancy, 16);
        chk("t4_ready", in_ready,  0);
        guard = 0;
        npop = 0;
        out_ready = 1;
        while (npop == 0 && guard < 4) begin do_cycle(); guard++; end
        if (npop == 0) timeout("t4_pop");
        out_ready = 0;
        do_cycle();
        in_valid = 0;
        do_cycle();
        chk("t4_refill", occupancy, 16);

        // 5: random stream with alternating out_ready across pointer wrap
        out_ready = 1;
        guard = 0;
        npush = 0;
        while (npush < 40 && guard < 3000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_core  = 4'($urandom);
            in_op    = 2'($urandom);
            in_addr  = {$urandom, $urandom} % (64'd1 << 34);
            in_cycle = ($urandom_range(0, 5) == 0) ? mtime + $urandom_range(1, 4)
                                                   : mtime - $urandom_range(0, 3);
            out_ready = ~out_ready;
            do_cycle();
            chk("t5_occ_bound", occupancy <= 16, 1);
            guard++;
        end
        if (npush < 40) timeout("t5_stream");
        in_valid = 0;
        guard = 0;
        while (mq.size() != 0 && guard < 200) begin
            out_ready = ~out_ready; do_cycle(); guard++;
        end
        if (mq.size() != 0) timeout("t5_drain");

        // 6: asynchronous reset mid-cycle with entries held
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_cycle = mtime; in_core = 4'(i + 9); in_op = 0;
            in_addr = 34'(i * 1234567);
            do_cycle();
        end
        in_valid = 0;
        chk("t6_held", occupancy, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_occ",   occupancy, 0);
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_time",  cpu_time,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        mtime = 0;
        repeat (3) do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr5_request_queue.md
Name: ddr5_request_queue

Overview:
- Bounded in-order queue between the trace-file reader / address-mapping stage and the DDR5 command scheduler.
- Accepts timestamped CPU requests and keeps simulated CPU time.
- Admits a request only when its arrival cycle has been reached, then stores it with its decoded DDR5 address fields.
- Presents the oldest request to the scheduler, on DRAM clock edges only.

Parameters:
- DEPTH, 16, queue entries; must be a power of 2, at least 2.
- TIME_W, 64, width of the CPU cycle counter and timestamps.
- CLK_RATIO, 2, CPU cycles per DRAM clock; must be a power of 2.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request offered.
- in_ready  out  1  request accepted this cycle when in_valid=1.
- in_cycle  in  TIME_W  request arrival CPU cycle.
- in_core  in  4  requesting core.
- in_op  in  2  0=data read, 1=data write, 2=instruction fetch, 3=reserved.
- in_addr  in  34  physical address.
- out_valid  out  1  head request available to the scheduler.
- out_ready  in  1  scheduler takes the head.
- out_op  out  2  head operation.
- out_core  out  4  head core.
- out_row  out  16  addr[33:18].
- out_col  out  10  {addr[17:12], addr[5:2]}.
- out_bank  out  2  addr[11:10].
- out_bg  out  3  addr[9:7].
- out_chan  out  1  addr[6].
- out_arrival  out  TIME_W  head in_cycle.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- full  out  1  occupancy==DEPTH.
- cpu_time  out  TIME_W  current simulated CPU cycle.

Behaviour:
Reset (async, any time including mid-transfer):
- All entries, pointers and occupancy clear; cpu_time=0.
- Outputs: out_valid=0, full=0, occupancy=0, out_* fields 0.

Time:
- cpu_time increments by 1 every clk by default.
- Time-skip: if occupancy==0 and in_valid=1 and in_cycle>cpu_time, cpu_time loads in_cycle on the next edge (no increment that cycle).
- cpu_time wraps modulo 2^TIME_W, with no special handling.

Enqueue:
- in_ready = !full && (in_cycle <= cpu_time). This is combinational.
- Push on in_valid && in_ready.
- The entry stores op, core, raw addr and in_cycle; tail pointer advances modulo DEPTH.

Dequeue:
- dram_edge = (cpu_time[$clog2(CLK_RATIO)-1:0] == 0).
- out_valid = (occupancy != 0) && dram_edge.
- Pop on out_valid && out_ready; head pointer advances modulo DEPTH.
- out_* fields are decoded from the head entry combinationally. They are valid only while out_valid=1 and are held stable otherwise.
- out_ready=1 with out_valid=0 has no effect.

Latency:
- A pushed entry is visible at the earliest on the next cycle that is a dram_edge.
- No empty-queue bypass.

Simultaneous events:
- Push and pop in the same cycle: occupancy unchanged.
- When full, in_ready=0 even if a pop happens the same cycle. The push lands the following cycle.
- Time-skip cannot coincide with a pop because the queue is empty.

Ordering:
- Strict FIFO.
- Pointers wrap cleanly; a full/empty ambiguity is impossible because occupancy is tracked separately.

in_op=3:
- Accepted and stored unchanged.
- Under QUEUE_TRACE_EN it also produces a warning.

Optional Feature:
QUEUE_TRACE_EN
- Defined:
  - Every push prints "t=<cpu_time> ENQ core op addr occ".
  - Every pop prints "t=<cpu_time> DEQ core op row bg bank col".
  - in_op==3 prints a warning.
  - A push attempted while full increments a 32-bit stall counter, reported at $finish via a final block.
- Undefined: no display statements and no stall counter; functional behaviour identical.

Decomposition:
- Shared package: op_e enum, addr_fields_t packed struct (row, col, bank, bg, chan), req_t struct (core, op, addr, cycle), and the field bit-position localparams.
- Sub-module ddr5_addr_decode: purely combinational, 34-bit address in, addr_fields_t out. The address-mapping stage reuses it.

Test Plan:
1. Assert rst_n=0 then release, in_valid=0 → out_valid=0, occupancy=0, cpu_time counts 0,1,2,…; in_ready=1 with in_cycle=0.
2. Push in_cycle=0, core=3, op=1, addr=34'h3FFFFFFFF, out_ready=1 → pop on the first even cpu_time after the push with row=FFFF, col=3FF, bank=3, bg=7, chan=1, core=3, op=1.
3. Empty queue, cpu_time=5, offer in_cycle=100 → cpu_time=100 next cycle, push that cycle, out_valid asserts at cpu_time=102.
4. out_ready=0, push 17 requests with in_cycle=0 → full=1, occupancy=16, in_ready=0 for the 17th. Pop one → 17th pushed the next cycle, occupancy returns to 16.
5. Stream 40 requests with alternating out_ready → pop order equals push order across pointer wrap; occupancy never exceeds 16.
6. Hold 5 entries, pulse rst_n low mid-cycle → occupancy=0 and out_valid=0 immediately; after release the queue is empty and cpu_time restarts at 0.
